// File: rtl/chroni_pkg.sv
// chroni_pkg: definitions shared by the chroni palette stage.
//   - register offsets on the CPU register bus
//   - RGB565 field extraction helpers
//   - palette byte-phase state and CPU read-source encodings
//   - default border colour loaded at reset
package chroni_pkg;

  localparam logic [1:0] REG_PAL_INDEX = 2'd0;
  localparam logic [1:0] REG_PAL_DATA  = 2'd1;
  localparam logic [1:0] REG_BORDER_LO = 2'd2;
  localparam logic [1:0] REG_BORDER_HI = 2'd3;

  localparam logic [15:0] DEFAULT_BORDER = 16'h10A3;

  typedef enum logic {PH_LO, PH_HI} phase_t;

  // Selects which value a pending CPU read returns once RAM data is back.
  typedef enum logic [1:0] {RD_DIRECT, RD_PAL_LO, RD_PAL_HI} rd_src_t;

  function automatic logic [4:0] rgb_r(input logic [15:0] c);
    return c[15:11];
  endfunction

  function automatic logic [5:0] rgb_g(input logic [15:0] c);
    return c[10:5];
  endfunction

  function automatic logic [4:0] rgb_b(input logic [15:0] c);
    return c[4:0];
  endfunction

endpackage

// File: rtl/chroni_palette_if.sv
// chroni_palette_if: CPU register bus of the palette stage.
//   reg_addr   register select (2 bits)
//   reg_wdata  write data (8 bits)
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe
//   reg_rdata  read data, valid while reg_rvalid is high; holds until next read
//   reg_rvalid one-cycle read-data strobe, two cycles after reg_re
interface chroni_palette_if;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       reg_rvalid;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata, reg_rvalid
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata, reg_rvalid
  );
endinterface

// File: rtl/chroni_palette_ram.sv
// chroni_palette_ram: 256x16 dual-port palette RAM, no reset.
//   vga_clk  clock for both ports
//   a_addr   display read address; a_q registered one cycle later
//   b_addr   CPU address; b_we/b_wdata write, b_q registered read
// Both ports are read-before-write: a read in the same cycle as a write
// to the same address returns the previous contents.
module chroni_palette_ram (
  input  logic        vga_clk,
  input  logic [7:0]  a_addr,
  output logic [15:0] a_q,
  input  logic [7:0]  b_addr,
  input  logic        b_we,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_q
);

  logic [15:0] mem [256];

  always_ff @(posedge vga_clk) begin
    if (b_we) begin
      mem[b_addr] <= b_wdata;
    end
  end

  always_ff @(posedge vga_clk) begin
    a_q <= mem[a_addr];
  end

  always_ff @(posedge vga_clk) begin
    b_q <= mem[b_addr];
  end

endmodule

// File: rtl/chroni_palette.sv
// chroni_palette: colour stage of the chroni video pipeline.
//   vga_clk, reset_n          pixel clock, synchronous active-low reset
//   pix_index/de/pf/hs/vs     per-dot inputs from the timing/render stage
//   vga_r/g/b, vga_hs/vs      RGB565 colour and syncs, exactly 2 cycles later
//   bus                       CPU register bus (PAL_INDEX, PAL_DATA,
//                             BORDER_LO, BORDER_HI)
// Blank dots are black, border dots use the border register, playfield
// dots look up the 256-entry palette.
module chroni_palette
  import chroni_pkg::*;
#(
  parameter logic [15:0] BORDER_RESET = DEFAULT_BORDER
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [7:0]       pix_index,
  input  logic             pix_de,
  input  logic             pix_pf,
  input  logic             pix_hs,
  input  logic             pix_vs,
  output logic [4:0]       vga_r,
  output logic [5:0]       vga_g,
  output logic [4:0]       vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  chroni_palette_if.slave  bus
);

  // Register-file state
  logic [7:0]  index;
  phase_t      phase;
  logic [7:0]  lo_hold;
  logic [7:0]  shadow;
  logic [15:0] border;

  // CPU read pipeline
  logic        rd_pend;
  rd_src_t     rd_src;
  logic [7:0]  rd_direct;
  logic [7:0]  rdata_q;
  logic        rvalid_q;

  // Display pipeline
  logic        de1, pf1, hs1, vs1;
  logic [15:0] pal_a_q;
  logic [15:0] pal_b_q;
  logic [15:0] colour;

  logic        cpu_wr;
  logic        cpu_rd;
  logic        pal_we;

  // A write wins over a simultaneous read; the read is dropped entirely.
  assign cpu_wr = bus.reg_we;
  assign cpu_rd = bus.reg_re & ~bus.reg_we;
  assign pal_we = cpu_wr && (bus.reg_addr == REG_PAL_DATA) && (phase == PH_HI);

  chroni_palette_ram u_ram (
    .vga_clk (vga_clk),
    .a_addr  (pix_index),
    .a_q     (pal_a_q),
    .b_addr  (index),
    .b_we    (pal_we),
    .b_wdata ({bus.reg_wdata, lo_hold}),
    .b_q     (pal_b_q)
  );

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      index     <= '0;
      phase     <= PH_LO;
      lo_hold   <= '0;
      shadow    <= '0;
      border    <= BORDER_RESET;
      rd_pend   <= 1'b0;
      rd_src    <= RD_DIRECT;
      rd_direct <= '0;
    end else begin
      rd_pend   <= cpu_rd;
      rd_src    <= RD_DIRECT;
      rd_direct <= '0;
      if (cpu_wr) begin
        case (bus.reg_addr)
          REG_PAL_INDEX: begin
            index   <= bus.reg_wdata;
            phase   <= PH_LO;
            lo_hold <= '0;
          end
          REG_PAL_DATA: begin
            if (phase == PH_LO) begin
              lo_hold <= bus.reg_wdata;
              phase   <= PH_HI;
            end else begin
              index <= index + 8'd1;
              phase <= PH_LO;
            end
          end
          REG_BORDER_LO: shadow <= bus.reg_wdata;
          REG_BORDER_HI: border <= {bus.reg_wdata, shadow};
        endcase
      end else if (cpu_rd) begin
        case (bus.reg_addr)
          REG_PAL_INDEX: rd_direct <= index;
          REG_PAL_DATA: begin
            // RAM port B is addressed by index now; the byte is chosen
            // when its data returns next cycle.
            if (phase == PH_LO) begin
              rd_src <= RD_PAL_LO;
              phase  <= PH_HI;
            end else begin
              rd_src <= RD_PAL_HI;
              index  <= index + 8'd1;
              phase  <= PH_LO;
            end
          end
          REG_BORDER_LO: rd_direct <= border[7:0];
          REG_BORDER_HI: rd_direct <= border[15:8];
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_pend;
      if (rd_pend) begin
        case (rd_src)
          RD_PAL_LO: rdata_q <= pal_b_q[7:0];
          RD_PAL_HI: rdata_q <= pal_b_q[15:8];
          default:   rdata_q <= rd_direct;
        endcase
      end
    end
  end

  assign bus.reg_rdata  = rdata_q;
  assign bus.reg_rvalid = rvalid_q;

  always_comb begin
    colour = '0;
    if (de1 && !pf1) begin
      colour = border;
    end else if (de1 && pf1) begin
      colour = pal_a_q;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      de1    <= 1'b0;
      pf1    <= 1'b0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      de1    <= pix_de;
      pf1    <= pix_pf;
      hs1    <= pix_hs;
      vs1    <= pix_vs;
      vga_r  <= rgb_r(colour);
      vga_g  <= rgb_g(colour);
      vga_b  <= rgb_b(colour);
      vga_hs <= hs1;
      vga_vs <= vs1;
    end
  end

endmodule

// File: tb/tb_chroni_palette.sv
module tb_chroni_palette;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pix_index;
  logic       pix_de, pix_pf, pix_hs, pix_vs;
  logic [4:0] vga_r;
  logic [5:0] vga_g;
  logic [4:0] vga_b;
  logic       vga_hs, vga_vs;

  chroni_palette_if bus();

  chroni_palette #(.BORDER_RESET(16'h10A3)) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .pix_index (pix_index),
    .pix_de    (pix_de),
    .pix_pf    (pix_pf),
    .pix_hs    (pix_hs),
    .pix_vs    (pix_vs),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .bus       (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } reg_op_t;

  typedef struct {
    logic [7:0]  idx;
    logic        de, pf, hs, vs;
    logic [15:0] exp;
  } dot_t;

  reg_op_t ops[$];
  dot_t    dots[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check_rgb(input string name, input logic [15:0] exp);
    check(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic add_op(input logic wr, input logic [1:0] a, input logic [7:0] d);
    reg_op_t o;
    o.wr = wr; o.addr = a; o.data = d;
    ops.push_back(o);
  endtask

  task automatic add_dot(input logic [7:0] i, input logic de, input logic pf,
                         input logic hs, input logic vs, input logic [15:0] e);
    dot_t d;
    d.idx = i; d.de = de; d.pf = pf; d.hs = hs; d.vs = vs; d.exp = e;
    dots.push_back(d);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_we    = 1'b1;
    tick();
    bus.reg_we    = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    bus.reg_addr = a;
    bus.reg_re   = 1'b1;
    tick();
    bus.reg_re   = 1'b0;
    check({name, "_rvalid_early"}, {15'd0, bus.reg_rvalid}, 16'd0);
    tick();
    check({name, "_rvalid"}, {15'd0, bus.reg_rvalid}, 16'd1);
    check({name, "_rdata"}, {8'd0, bus.reg_rdata}, {8'd0, exp});
  endtask

  task automatic set_pix(input logic [7:0] i, input logic de, input logic pf,
                         input logic hs, input logic vs);
    pix_index = i; pix_de = de; pix_pf = pf; pix_hs = hs; pix_vs = vs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    bus.reg_we    = 1'b0;
    bus.reg_re    = 1'b0;
    set_pix(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset: syncs driven low on input so the reset value 1 is distinct.
    reset_n = 1'b0;
    tick(); tick(); tick();
    check_rgb("reset_rgb", 16'h0000);
    check("reset_syncs", {14'd0, vga_hs, vga_vs}, 16'h0003);
    check("reset_rvalid", {15'd0, bus.reg_rvalid}, 16'd0);
    check("reset_rdata", {8'd0, bus.reg_rdata}, 16'd0);
    reset_n = 1'b1;
    tick();
    check_rgb("post_reset_c1_rgb", 16'h0000);
    check("post_reset_c1_syncs", {14'd0, vga_hs, vga_vs}, 16'h0003);
    tick();
    check_rgb("post_reset_border", 16'h10A3);
    check("post_reset_border_r", {11'd0, vga_r}, 16'h0002);
    check("post_reset_border_g", {10'd0, vga_g}, 16'h0005);
    check("post_reset_border_b", {11'd0, vga_b}, 16'h0003);
    check("post_reset_syncs", {14'd0, vga_hs, vga_vs}, 16'h0000);
    set_pix(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Register table: writes, and reads with hand-computed results.
    add_op(1, 0, 8'hFF); add_op(1, 1, 8'h1F); add_op(1, 1, 8'hF8); add_op(0, 0, 8'h00);
    add_op(1, 0, 8'hFF); add_op(0, 1, 8'h1F); add_op(0, 1, 8'hF8); add_op(0, 0, 8'h00);
    add_op(0, 2, 8'hA3); add_op(0, 3, 8'h10);
    add_op(1, 0, 8'h10); add_op(1, 1, 8'h34); add_op(1, 1, 8'h12); add_op(1, 0, 8'h10);
    add_op(0, 1, 8'h34); add_op(0, 1, 8'h12); add_op(0, 0, 8'h11);
    add_op(1, 0, 8'h20); add_op(1, 1, 8'hAA); add_op(1, 0, 8'h20); add_op(1, 1, 8'h55);
    add_op(1, 1, 8'h66); add_op(1, 0, 8'h20); add_op(0, 1, 8'h55); add_op(0, 1, 8'h66);
    add_op(0, 0, 8'h21);
    add_op(1, 0, 8'h03); add_op(1, 1, 8'h0D); add_op(1, 1, 8'h0C);
    add_op(1, 0, 8'h05); add_op(1, 1, 8'h11); add_op(1, 1, 8'h11); add_op(0, 0, 8'h06);
    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i].wr) reg_write(ops[i].addr, ops[i].data);
      else reg_read(ops[i].addr, ops[i].data, $sformatf("regvec%0d", i));
    end

    // Palette 255 with an hsync pulse: appears exactly 2 cycles later.
    tick(); tick();
    set_pix(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_pix(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_rgb("p255_c1_rgb", 16'h0000);
    check("p255_c1_hs", {15'd0, vga_hs}, 16'd1);
    tick();
    check_rgb("p255_rgb", 16'hF81F);
    check("p255_hs", {15'd0, vga_hs}, 16'd0);
    tick();
    check_rgb("p255_after_rgb", 16'h0000);
    check("p255_after_hs", {15'd0, vga_hs}, 16'd1);

    // Streamed dots, one per cycle.
    add_dot(8'hFF, 1, 1, 0, 1, 16'hF81F);
    add_dot(8'h10, 1, 1, 1, 1, 16'h1234);
    add_dot(8'h20, 1, 1, 1, 0, 16'h6655);
    add_dot(8'h03, 1, 1, 1, 1, 16'h0C0D);
    add_dot(8'h05, 1, 1, 0, 0, 16'h1111);
    add_dot(8'h07, 0, 1, 1, 1, 16'h0000);
    add_dot(8'hFF, 1, 0, 1, 1, 16'h10A3);
    add_dot(8'h03, 0, 0, 0, 0, 16'h0000);
    for (int i = 0; i <= dots.size(); i++) begin
      if (i < dots.size()) set_pix(dots[i].idx, dots[i].de, dots[i].pf, dots[i].hs, dots[i].vs);
      else set_pix(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      if (i >= 1) begin
        check_rgb($sformatf("dot%0d_rgb", i - 1), dots[i - 1].exp);
        check($sformatf("dot%0d_syncs", i - 1), {14'd0, vga_hs, vga_vs},
              {14'd0, dots[i - 1].hs, dots[i - 1].vs});
      end
    end

    // Back-to-back PAL_DATA reads from index 3.
    reg_write(0, 8'h03);
    bus.reg_addr = 2'd1;
    bus.reg_re   = 1'b1;
    tick();
    check("b2b_n1_rvalid", {15'd0, bus.reg_rvalid}, 16'd0);
    tick();
    bus.reg_re = 1'b0;
    check("b2b_n2_rvalid", {15'd0, bus.reg_rvalid}, 16'd1);
    check("b2b_n2_rdata", {8'd0, bus.reg_rdata}, 16'h000D);
    tick();
    check("b2b_n3_rvalid", {15'd0, bus.reg_rvalid}, 16'd1);
    check("b2b_n3_rdata", {8'd0, bus.reg_rdata}, 16'h000C);
    tick();
    check("b2b_n4_rvalid", {15'd0, bus.reg_rvalid}, 16'd0);
    check("b2b_hold_rdata", {8'd0, bus.reg_rdata}, 16'h000C);
    reg_read(0, 8'h04, "b2b_index");

    // Border: low byte alone does nothing visible; high byte commits.
    set_pix(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    reg_write(2, 8'h00);
    tick(); tick();
    check_rgb("border_lo_only", 16'h10A3);
    reg_write(3, 8'hFF);
    tick(); tick();
    check_rgb("border_commit", 16'hFF00);
    reg_read(2, 8'h00, "border_rd_lo");
    reg_read(3, 8'hFF, "border_rd_hi");

    // Read-before-write: CPU commits palette[5] while the display reads it.
    reg_write(0, 8'h05);
    reg_write(1, 8'h22);
    bus.reg_addr  = 2'd1;
    bus.reg_wdata = 8'hE0;
    bus.reg_we    = 1'b1;
    set_pix(8'h05, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    bus.reg_we = 1'b0;
    tick();
    check_rgb("rbw_old", 16'h1111);
    tick();
    check_rgb("rbw_new", 16'hE022);

    // Simultaneous write and read: write happens, no rvalid.
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 8'h77;
    bus.reg_we    = 1'b1;
    bus.reg_re    = 1'b1;
    tick();
    bus.reg_we = 1'b0;
    bus.reg_re = 1'b0;
    check("wr_rd_c1_rvalid", {15'd0, bus.reg_rvalid}, 16'd0);
    tick();
    check("wr_rd_c2_rvalid", {15'd0, bus.reg_rvalid}, 16'd0);
    tick();
    check("wr_rd_c3_rvalid", {15'd0, bus.reg_rvalid}, 16'd0);
    reg_read(0, 8'h77, "wr_rd_index");

    // Mid-line reset with the phase left at HI and a non-zero shadow.
    reg_write(2, 8'h5A);
    reg_write(0, 8'h00);
    reg_write(1, 8'hAB);
    set_pix(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    check_rgb("midline_pre_rgb", 16'hF81F);
    reset_n = 1'b0;
    tick();
    check_rgb("midline_reset_rgb", 16'h0000);
    check("midline_reset_syncs", {14'd0, vga_hs, vga_vs}, 16'h0003);
    check("midline_reset_rdata", {8'd0, bus.reg_rdata}, 16'd0);
    reset_n = 1'b1;
    set_pix(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    reg_write(1, 8'hCD);
    reg_write(1, 8'hEF);
    reg_read(0, 8'h01, "midline_index");
    reg_write(0, 8'h00);
    reg_read(1, 8'hCD, "midline_pal_lo");
    reg_read(1, 8'hEF, "midline_pal_hi");
    reg_read(2, 8'hA3, "midline_border_lo");
    reg_read(3, 8'h10, "midline_border_hi");
    reg_write(3, 8'h12);
    reg_read(2, 8'h00, "midline_shadow_lo");
    reg_read(3, 8'h12, "midline_shadow_hi");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chroni_palette.md
# chroni_palette

Downstream colour stage of the chroni video pipeline. Accepts the per-dot 8-bit pixel index, display-enable, playfield and sync signals from the chroni timing/render stage, and looks up RGB565 colour in a 256-entry CPU-writable palette. Outputs the VGA colour and sync pins with all signals delay-matched. Border colour comes from a dedicated register; blanking forces black.

## Interface
- BORDER_RESET, 16'h10A3: border colour after reset, RGB565.
- vga_clk  in  1  pixel clock; every register in the block is clocked here.
- reset_n  in  1  synchronous, active-low reset.
- pix_index  in  8  palette index for the current dot.
- pix_de  in  1  display enable; low means blank.
- pix_pf  in  1  playfield active; low inside DE means border.
- pix_hs, pix_vs  in  1 each  syncs, polarity already applied upstream.
- vga_r  out  5, vga_g  out  6, vga_b  out  5  colour outputs.
- vga_hs, vga_vs  out  1 each  delayed syncs.
- reg_addr  in  2  register select.
- reg_wdata  in  8  write data.
- reg_we  in  1  one-cycle write strobe.
- reg_re  in  1  one-cycle read strobe.
- reg_rdata  out  8  read data, valid while reg_rvalid is high.
- reg_rvalid  out  1  one-cycle read-data strobe.

## Operation
- Registers:
  - 0 PAL_INDEX: write sets the index and forces byte phase to LO; read returns the index.
  - 1 PAL_DATA: byte-phase access to the palette.
  - 2 BORDER_LO: write goes to a shadow register.
  - 3 BORDER_HI: write commits {wdata, shadow} to the border register atomically.
  - Reads of registers 2 and 3 return the committed border bytes.
- PAL_DATA writes use a two-state phase FSM.
  - LO: latch wdata into lo_hold; go to HI.
  - HI: write {wdata, lo_hold} to palette[index]; index <= index+1, wrapping 255->0; go to LO.
- PAL_DATA reads use the same FSM.
  - LO: return palette[index][7:0]; go to HI.
  - HI: return palette[index][15:8]; index+1 with wrap; go to LO.
- reg_we and reg_re in the same cycle: the write executes, the read is dropped and reg_rvalid stays low.
- Writing PAL_INDEX while the phase is HI discards lo_hold and returns the phase to LO.
- Colour select, per dot, from the inputs delayed 2 cycles:
  - !de -> 0.
  - de & !pf -> border.
  - de & pf -> palette[index].
- Palette RAM contents are not reset. Reset clears index, phase, lo_hold and shadow, and loads border with BORDER_RESET.

## Timing
- Display path latency is exactly 2 vga_clk cycles, from pix_* to vga_* including syncs.
  - Stage 0: register index/de/pf/hs/vs; RAM address presented.
  - Stage 1: RAM data available; delay registers.
  - Stage 2: mux result and syncs registered onto the outputs.
- Reset values: vga_r/g/b = 0, vga_hs = vga_vs = 1, reg_rdata = 0, reg_rvalid = 0; all pipeline de/pf stages = 0.
- During reset and for the 2 cycles after release, outputs are black with syncs at 1.
- Palette RAM is dual-port: port A is the display read, port B is CPU read/write.
- Same-address CPU write and display read in one cycle: the display sees the old data (read-before-write). The new value is visible to a display read issued the next cycle.
- CPU read: reg_re in cycle N -> reg_rdata/reg_rvalid in cycle N+2. reg_rdata holds until the next read.
- Back-to-back reg_re every cycle is supported; each read produces its own rvalid 2 cycles later.
- A border commit affects dots whose stage-0 sample is taken 1 cycle or more after the BORDER_HI write.
- Reset asserted mid-line: the pipeline flushes, the FSM returns to LO and outputs go to reset values on the next edge.

## Structure
- Shared package chroni_pkg:
  - register offsets REG_PAL_INDEX=0, REG_PAL_DATA=1, REG_BORDER_LO=2, REG_BORDER_HI=3;
  - RGB565 field slices;
  - phase enum {PH_LO, PH_HI};
  - default border constant.
- Sub-module chroni_palette_ram: 256x16 true dual-port RAM, 1-cycle registered read, read-before-write, no reset.
- Top level holds the register FSM, the delay pipeline and the output mux.

## Test plan
- Reset with pix_de=1, pix_pf=0 -> after 2 cycles, RGB = 10A3 split: r=5'h02, g=6'h05, b=5'h03; during reset all colour outputs are 0 and hs/vs=1.
- Write PAL_INDEX=8'hFF, PAL_DATA=8'h1F, PAL_DATA=8'hF8 -> palette[255]=16'hF81F; PAL_INDEX reads back 8'h00 (wrap).
- Drive pix_index=255 with de=pf=1 -> vga_r=5'h1F, vga_g=0, vga_b=5'h1F exactly 2 cycles after the input; pix_hs pulse is aligned on the same cycle.
- Set PAL_INDEX=3 then issue reg_re on PAL_DATA in cycles N and N+1 -> rvalid in N+2 and N+3 with the low then high byte; PAL_INDEX then reads 4.
- Write BORDER_LO=8'h00 only -> border output is unchanged; then write BORDER_HI=8'hFF -> border becomes 16'hFF00.
- Same cycle: CPU writes HI byte to palette[5] and the display reads index 5 -> display shows the old value, the next dot shows the new one. Separately, reg_we with reg_re -> no rvalid.
